// File: rtl/li_encoder_if.sv
// li_encoder_if: request/response bundle for the load-immediate encoder.
//   Request side : in_valid, in_ready, in_value[31:0], in_rt[4:0]
//   Response side: out_valid, out_ready, out_instr[31:0], out_extop[1:0],
//                  out_last, instr_cnt[15:0]
// The master modport belongs to the producer/consumer environment and the
// slave modport to the encoder.
interface li_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic [4:0]  in_rt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [1:0]  out_extop;
    logic        out_last;
    logic [15:0] instr_cnt;

    modport master (
        output in_valid, in_value, in_rt, out_ready,
        input  in_ready, out_valid, out_instr, out_extop, out_last, instr_cnt
    );

    modport slave (
        input  in_valid, in_value, in_rt, out_ready,
        output in_ready, out_valid, out_instr, out_extop, out_last, instr_cnt
    );
endinterface

// File: rtl/li_encoder.sv
// li_encoder: turns a 32-bit constant plus destination register into the
// shortest MIPS sequence (addiu / ori / lui, or lui+ori) that rebuilds it,
// tagging every word with the immediate-extension code the decoder needs.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : li_encoder_if.slave (request in, instruction words out, counter)
// All outputs are registered; a request is classified once at acceptance.
module li_encoder (
    input  logic         clk,
    input  logic         rst,
    li_encoder_if.slave  bus
);
    localparam logic [1:0] EXT_ZERO    = 2'b00;
    localparam logic [1:0] EXT_SIGNED  = 2'b01;
    localparam logic [1:0] EXT_HIGHPOS = 2'b10;

    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EMIT1 = 2'd1,
        S_EMIT2 = 2'd2
    } state_e;

    state_e      state_q,     state_d;
    logic        in_ready_q,  in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [1:0]  out_extop_q, out_extop_d;
    logic        out_last_q,  out_last_d;
    logic [31:0] instr2_q,    instr2_d;
    logic [15:0] cnt_q,       cnt_d;

    logic [31:0] first_instr_s;
    logic [1:0]  first_extop_s;
    logic        first_last_s;

    // Classify the incoming constant; earlier rules win over later ones.
    always_comb begin
        first_instr_s = {OP_LUI, 5'd0, bus.in_rt, bus.in_value[31:16]};
        first_extop_s = EXT_HIGHPOS;
        first_last_s  = 1'b0;
        if ((&bus.in_value[31:15]) || !(|bus.in_value[31:15])) begin
            first_instr_s = {OP_ADDIU, 5'd0, bus.in_rt, bus.in_value[15:0]};
            first_extop_s = EXT_SIGNED;
            first_last_s  = 1'b1;
        end else if (bus.in_value[31:16] == 16'h0000) begin
            first_instr_s = {OP_ORI, 5'd0, bus.in_rt, bus.in_value[15:0]};
            first_extop_s = EXT_ZERO;
            first_last_s  = 1'b1;
        end else if (bus.in_value[15:0] == 16'h0000) begin
            first_instr_s = {OP_LUI, 5'd0, bus.in_rt, bus.in_value[31:16]};
            first_extop_s = EXT_HIGHPOS;
            first_last_s  = 1'b1;
        end else begin
            first_instr_s = {OP_LUI, 5'd0, bus.in_rt, bus.in_value[31:16]};
            first_extop_s = EXT_HIGHPOS;
            first_last_s  = 1'b0;
        end
    end

    // Next-state and next-output computation for the emit sequencer.
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_extop_d = out_extop_q;
        out_last_d  = out_last_q;
        instr2_d    = instr2_q;
        cnt_d       = cnt_q;

        if (out_valid_q && bus.out_ready) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    state_d     = S_EMIT1;
                    in_ready_d  = 1'b0;
                    out_valid_d = 1'b1;
                    out_instr_d = first_instr_s;
                    out_extop_d = first_extop_s;
                    out_last_d  = first_last_s;
                    // The ori half writes back into rt, so rs = rt here.
                    instr2_d    = {OP_ORI, bus.in_rt, bus.in_rt, bus.in_value[15:0]};
                end else begin
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end
            end
            S_EMIT1: begin
                if (bus.out_ready) begin
                    if (out_last_q) begin
                        state_d     = S_IDLE;
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b0;
                    end else begin
                        state_d     = S_EMIT2;
                        out_instr_d = instr2_q;
                        out_extop_d = EXT_ZERO;
                        out_last_d  = 1'b1;
                    end
                end else begin
                    state_d = S_EMIT1;
                end
            end
            S_EMIT2: begin
                if (bus.out_ready) begin
                    state_d     = S_IDLE;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end else begin
                    state_d = S_EMIT2;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset overrides any handshake in the cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_instr_q <= 32'd0;
            out_extop_q <= 2'd0;
            out_last_q  <= 1'b0;
            instr2_q    <= 32'd0;
            cnt_q       <= 16'd0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_extop_q <= out_extop_d;
            out_last_q  <= out_last_d;
            instr2_q    <= instr2_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_extop = out_extop_q;
    assign bus.out_last  = out_last_q;
    assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_li_encoder.sv
// tb_li_encoder: directed and randomized requests for li_encoder, compared
// against a reference built from the MIPS immediate-extension rules.
module tb_li_encoder;
    localparam logic [1:0] EXT_ZERO    = 2'b00;
    localparam logic [1:0] EXT_SIGNED  = 2'b01;
    localparam logic [1:0] EXT_HIGHPOS = 2'b10;

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  extop;
        logic        last;
    } word_t;

    logic clk;
    logic rst;
    li_encoder_if bus ();

    li_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total_cnt;
    int bad_cnt;
    logic [15:0] model_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it when it does not hold.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        if (got !== exp) begin
            bad_cnt = bad_cnt + 1;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Reference: which words an extending decoder needs to rebuild the value.
    function automatic void build_words(input logic [31:0] value, input logic [4:0] rt,
                                        output word_t q[$]);
        int    sv;
        word_t w;
        q  = {};
        sv = $signed(value);
        if (sv >= -32768 && sv <= 32767) begin
            w.instr = {6'h09, 5'd0, rt, value[15:0]}; w.extop = EXT_SIGNED; w.last = 1'b1;
            q.push_back(w);
        end else if (value < 32'd65536) begin
            w.instr = {6'h0D, 5'd0, rt, value[15:0]}; w.extop = EXT_ZERO; w.last = 1'b1;
            q.push_back(w);
        end else if ((value % 32'd65536) == 32'd0) begin
            w.instr = {6'h0F, 5'd0, rt, value[31:16]}; w.extop = EXT_HIGHPOS; w.last = 1'b1;
            q.push_back(w);
        end else begin
            w.instr = {6'h0F, 5'd0, rt, value[31:16]}; w.extop = EXT_HIGHPOS; w.last = 1'b0;
            q.push_back(w);
            w.instr = {6'h0D, rt, rt, value[15:0]}; w.extop = EXT_ZERO; w.last = 1'b1;
            q.push_back(w);
        end
    endfunction

    // Issue one request from an idle negedge and drain all of its words.
    // stall<0 gives random backpressure, otherwise a fixed number of low
    // out_ready cycles per word. While words drain, in_valid carries the
    // optional pending request. Returns at the negedge after the last word.
    task automatic run_req(input logic [31:0] value, input logic [4:0] rt, input int stall,
                           input bit pend, input logic [31:0] pv, input logic [4:0] prt);
        word_t q[$];
        int    waited;
        bit    done;
        bit    rdy;
        build_words(value, rt, q);
        check_eq("idle_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("idle_out_valid", 32'(bus.out_valid), 32'd0);
        bus.in_valid  = 1'b1;
        bus.in_value  = value;
        bus.in_rt     = rt;
        bus.out_ready = 1'b0;
        @(posedge clk);
        foreach (q[i]) begin
            waited = 0;
            done   = 1'b0;
            while (!done) begin
                @(negedge clk);
                bus.in_valid = pend;
                if (pend) begin
                    bus.in_value = pv;
                    bus.in_rt    = prt;
                end
                check_eq("busy_out_valid", 32'(bus.out_valid), 32'd1);
                check_eq("busy_in_ready", 32'(bus.in_ready), 32'd0);
                check_eq("word_instr", bus.out_instr, q[i].instr);
                check_eq("word_extop", 32'(bus.out_extop), 32'(q[i].extop));
                check_eq("word_last", 32'(bus.out_last), 32'(q[i].last));
                if (stall < 0) rdy = ($urandom_range(0, 2) != 0) || (waited >= 8);
                else           rdy = (waited >= stall);
                bus.out_ready = rdy;
                @(posedge clk);
                if (rdy) begin
                    done      = 1'b1;
                    model_cnt = model_cnt + 16'd1;
                end else begin
                    waited = waited + 1;
                end
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_eq("done_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("done_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("done_instr_cnt", 32'(bus.instr_cnt), 32'(model_cnt));
    endtask

    // Main sequence: reset, directed cases, random cases, counter wrap, reset mid-sequence.
    initial begin
        logic [31:0] rv;
        logic [4:0]  rrt;
        total_cnt     = 0;
        bad_cnt       = 0;
        model_cnt     = 16'd0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_value  = 32'd0;
        bus.in_rt     = 5'd0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("rst_out_instr", bus.out_instr, 32'd0);
        check_eq("rst_out_extop", 32'(bus.out_extop), 32'd0);
        check_eq("rst_out_last", 32'(bus.out_last), 32'd0);
        check_eq("rst_instr_cnt", 32'(bus.instr_cnt), 32'd0);

        run_req(32'hFFFF8000, 5'd8, 0, 1'b0, 32'd0, 5'd0);
        run_req(32'h00001234, 5'd3, 1, 1'b0, 32'd0, 5'd0);
        run_req(32'h0000ABCD, 5'd9, 0, 1'b0, 32'd0, 5'd0);
        run_req(32'h12340000, 5'd10, 2, 1'b0, 32'd0, 5'd0);
        run_req(32'hDEADBEEF, 5'd16, 3, 1'b0, 32'd0, 5'd0);
        run_req(32'h00008000, 5'd0, 0, 1'b0, 32'd0, 5'd0);
        run_req(32'hFFFF7FFF, 5'd31, 0, 1'b0, 32'd0, 5'd0);
        run_req(32'h00010000, 5'd1, 0, 1'b0, 32'd0, 5'd0);

        for (int n = 0; n < 40; n++) begin
            rrt = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0: rv = {{16{1'($urandom_range(0, 1))}}, 1'b0, 15'($urandom)};
                1: rv = {16'h0000, 1'b1, 15'($urandom)};
                2: rv = {16'($urandom), 16'h0000};
                default: rv = $urandom;
            endcase
            if (rv[31:16] == 16'hFFFF) rv[15] = 1'b1;
            run_req(rv, rrt, -1, 1'b0, 32'd0, 5'd0);
        end

        // Request held during EMIT1 must wait for IDLE and run exactly once.
        run_req(32'h00000042, 5'd4, 2, 1'b1, 32'h87654321, 5'd5);
        run_req(32'h87654321, 5'd5, 0, 1'b0, 32'd0, 5'd0);
        @(negedge clk);
        check_eq("held_req_once", 32'(bus.out_valid), 32'd0);

        // Counter wrap: jump the counter to 0xFFFF while idle.
        force dut.cnt_q = 16'hFFFF;
        #1;
        release dut.cnt_q;
        model_cnt = 16'hFFFF;
        @(negedge clk);
        check_eq("cnt_preload", 32'(bus.instr_cnt), 32'h0000FFFF);
        run_req(32'h00000007, 5'd2, 0, 1'b0, 32'd0, 5'd0);
        check_eq("cnt_wrap", 32'(bus.instr_cnt), 32'd0);

        // Reset held two cycles while the ori word is pending.
        bus.in_valid  = 1'b1;
        bus.in_value  = 32'hCAFEF00D;
        bus.in_rt     = 5'd12;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("emit2_instr", bus.out_instr, {6'h0D, 5'd12, 5'd12, 16'hF00D});
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b0;
        model_cnt = 16'd0;
        check_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("midrst_instr_cnt", 32'(bus.instr_cnt), 32'd0);
        check_eq("midrst_out_last", 32'(bus.out_last), 32'd0);
        @(negedge clk);
        check_eq("midrst_no_word", 32'(bus.out_valid), 32'd0);
        run_req(32'hDEADBEEF, 5'd16, 0, 1'b0, 32'd0, 5'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end
endmodule
